// File: rtl/s9io_pkg.sv
// rtl/s9io_pkg.sv - shared register map, field positions and mode encodings for s9io_irq_ctrl
package s9io_pkg;

    localparam int REG_ADDR_W = 9;
    localparam int REG_DATA_W = 32;

    // Per-channel register offsets inside the 0x10-byte channel window
    localparam logic [3:0] OFS_CTRL    = 4'h0;
    localparam logic [3:0] OFS_THR     = 4'h4;
    localparam logic [3:0] OFS_STAT    = 4'h8;
    localparam logic [3:0] OFS_ERR_CNT = 4'hC;

    localparam logic [REG_ADDR_W-1:0] IRQ_SUMMARY_ADDR = 9'h100;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int STAT_PEND_BIT = 0;
    localparam int STAT_LVL_LSB  = 16;

    typedef enum logic [1:0] {
        MODE_GE    = 2'd0,   // lvl >= THR
        MODE_LT    = 2'd1,   // lvl <  THR
        MODE_NZ    = 2'd2,   // lvl != 0
        MODE_NEVER = 2'd3
    } irq_mode_e;

endpackage

// File: rtl/s9io_irq_ctrl_if.sv
// rtl/s9io_irq_ctrl_if.sv - register access bus for s9io_irq_ctrl
//
// Signals: reg_wr / reg_rd strobes, reg_addr byte address (word aligned),
// reg_wdata write data, reg_rdata read data (valid one cycle after reg_rd).
// master drives the strobes/address/data, slave returns reg_rdata.
interface s9io_irq_ctrl_if;
    import s9io_pkg::*;

    logic                  reg_wr;
    logic                  reg_rd;
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [REG_DATA_W-1:0] reg_wdata;
    logic [REG_DATA_W-1:0] reg_rdata;

    modport master (
        output reg_wr, reg_rd, reg_addr, reg_wdata,
        input  reg_rdata
    );

    modport slave (
        input  reg_wr, reg_rd, reg_addr, reg_wdata,
        output reg_rdata
    );
endinterface

// File: rtl/s9io_irq_ch.sv
// rtl/s9io_irq_ch.sv - per-channel CTRL/THR/pending/ERR_CNT state for s9io_irq_ctrl
//
// Ports: clk, rst (async active-high); lvl live FIFO level; err_evt drop pulse;
// wr_ctrl/wr_thr/wr_stat/wr_err decoded write strobes with shared wdata;
// outputs ctrl_en, ctrl_mode, thr, pending, err_cnt for readback and irq logic.
module s9io_irq_ch
    import s9io_pkg::*;
#(
    parameter int LVL_W = 10,
    parameter int ERR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LVL_W-1:0]      lvl,
    input  logic                  err_evt,
    input  logic                  wr_ctrl,
    input  logic                  wr_thr,
    input  logic                  wr_stat,
    input  logic                  wr_err,
    input  logic [REG_DATA_W-1:0] wdata,
    output logic                  ctrl_en,
    output irq_mode_e             ctrl_mode,
    output logic [LVL_W-1:0]      thr,
    output logic                  pending,
    output logic [ERR_W-1:0]      err_cnt
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    logic cond;
    logic unused_wdata;

    // Only the low bits of wdata carry fields; the rest is intentionally dropped.
    assign unused_wdata = ^wdata;

    always_comb begin
        cond = 1'b0;
        case (ctrl_mode)
            MODE_GE:    cond = (lvl >= thr);
            MODE_LT:    cond = (lvl < thr);
            MODE_NZ:    cond = (lvl != '0);
            default:    cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= MODE_GE;
            thr       <= '0;
            pending   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en   <= wdata[CTRL_EN_BIT];
                ctrl_mode <= irq_mode_e'(wdata[CTRL_MODE_LSB +: 2]);
            end
            if (wr_thr) begin
                thr <= wdata[LVL_W-1:0];
            end
            // Set has priority over W1C so a still-true condition is never lost.
            if (cond) begin
                pending <= 1'b1;
            end else if (wr_stat && wdata[STAT_PEND_BIT]) begin
                pending <= 1'b0;
            end
            // A write clears the counter but still accounts for a coincident event.
            if (wr_err) begin
                err_cnt <= err_evt ? ERR_W'(1) : '0;
            end else if (err_evt && (err_cnt != ERR_MAX)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/s9io_irq_ctrl.sv
// rtl/s9io_irq_ctrl.sv - FIFO level / error interrupt controller with per-channel registers
//
// Ports: clk, rst (async active-high); fifo_lvl NUM_CH*LVL_W live levels (ch0 in LSBs);
// err_evt NUM_CH drop pulses; bus (s9io_irq_ctrl_if.slave) register access;
// irq aggregated interrupt.
// Optional feature: define S9IO_IRQ_COALESCE_EN to delay irq until an enabled
// pending has been held for COAL_CYCLES consecutive cycles.
module s9io_irq_ctrl
    import s9io_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int LVL_W       = 10,
    parameter int ERR_W       = 16,
    parameter int COAL_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*LVL_W-1:0] fifo_lvl,
    input  logic [NUM_CH-1:0]       err_evt,
    s9io_irq_ctrl_if.slave          bus,
    output logic                    irq
);

    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] ch_pend;
    irq_mode_e         ch_mode [NUM_CH];
    logic [LVL_W-1:0]  ch_thr  [NUM_CH];
    logic [LVL_W-1:0]  ch_lvl  [NUM_CH];
    logic [ERR_W-1:0]  ch_err  [NUM_CH];

    logic                  any_pend;
    logic [REG_DATA_W-1:0] rd_val;

    // Channel windows live below 0x100; bit 8 selects the global space.
    logic in_ch_space;
    assign in_ch_space = ~bus.reg_addr[8];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic ch_sel;
        assign ch_sel      = bus.reg_wr && in_ch_space && (bus.reg_addr[7:4] == 4'(g));
        assign ch_lvl[g]   = fifo_lvl[g*LVL_W +: LVL_W];

        s9io_irq_ch #(
            .LVL_W (LVL_W),
            .ERR_W (ERR_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .lvl       (ch_lvl[g]),
            .err_evt   (err_evt[g]),
            .wr_ctrl   (ch_sel && (bus.reg_addr[3:0] == OFS_CTRL)),
            .wr_thr    (ch_sel && (bus.reg_addr[3:0] == OFS_THR)),
            .wr_stat   (ch_sel && (bus.reg_addr[3:0] == OFS_STAT)),
            .wr_err    (ch_sel && (bus.reg_addr[3:0] == OFS_ERR_CNT)),
            .wdata     (bus.reg_wdata),
            .ctrl_en   (ch_en[g]),
            .ctrl_mode (ch_mode[g]),
            .thr       (ch_thr[g]),
            .pending   (ch_pend[g]),
            .err_cnt   (ch_err[g])
        );
    end

    assign any_pend = |(ch_pend & ch_en);

    always_comb begin
        rd_val = '0;
        if (bus.reg_addr == IRQ_SUMMARY_ADDR) begin
            rd_val = REG_DATA_W'(ch_pend & ch_en);
        end else if (in_ch_space) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.reg_addr[7:4] == 4'(i)) begin
                    case (bus.reg_addr[3:0])
                        OFS_CTRL:    rd_val = REG_DATA_W'({ch_mode[i], ch_en[i]});
                        OFS_THR:     rd_val = REG_DATA_W'(ch_thr[i]);
                        OFS_STAT:    rd_val = (REG_DATA_W'(ch_lvl[i]) << STAT_LVL_LSB)
                                            | REG_DATA_W'(ch_pend[i]);
                        OFS_ERR_CNT: rd_val = REG_DATA_W'(ch_err[i]);
                        default:     rd_val = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.reg_rdata <= '0;
        end else if (bus.reg_rd) begin
            bus.reg_rdata <= rd_val;
        end
    end

`ifdef S9IO_IRQ_COALESCE_EN
    localparam int CNT_W = $clog2(COAL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COAL_CYCLES);

    logic [CNT_W-1:0] coal_cnt;

    // coal_cnt counts consecutive cycles with an enabled pending; irq rises on
    // the cycle the count reaches COAL_CYCLES and stays up while one remains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coal_cnt <= '0;
            irq      <= 1'b0;
        end else if (!any_pend) begin
            coal_cnt <= '0;
            irq      <= 1'b0;
        end else if (coal_cnt != CNT_MAX) begin
            coal_cnt <= coal_cnt + 1'b1;
            irq      <= ((coal_cnt + 1'b1) == CNT_MAX);
        end else begin
            irq      <= 1'b1;
        end
    end
`else
    localparam int unused_coal_cycles = COAL_CYCLES;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= any_pend;
        end
    end
`endif

endmodule

// File: tb/tb_s9io_irq_ctrl.sv
// tb/tb_s9io_irq_ctrl.sv - directed self-checking bench for s9io_irq_ctrl
module tb_s9io_irq_ctrl;

    localparam int NUM_CH = 4;
    localparam int LVL_W  = 10;
    localparam int ERR_W  = 4;
    localparam int COAL   = 64;

`ifdef S9IO_IRQ_COALESCE_EN
    localparam logic FAST_IRQ = 1'b0;
`else
    localparam logic FAST_IRQ = 1'b1;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_CH*LVL_W-1:0] fifo_lvl = '0;
    logic [NUM_CH-1:0]       err_evt = '0;
    logic                    irq;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] rv;

    s9io_irq_ctrl_if bus_if ();

    s9io_irq_ctrl #(
        .NUM_CH      (NUM_CH),
        .LVL_W       (LVL_W),
        .ERR_W       (ERR_W),
        .COAL_CYCLES (COAL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fifo_lvl (fifo_lvl),
        .err_evt  (err_evt),
        .bus      (bus_if),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_lvl(input int ch, input logic [LVL_W-1:0] v);
        fifo_lvl[ch*LVL_W +: LVL_W] = v;
    endtask

    task automatic reg_write(input logic [8:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.reg_wr    = 1'b1;
        bus_if.reg_addr  = a;
        bus_if.reg_wdata = d;
        @(negedge clk);
        bus_if.reg_wr    = 1'b0;
    endtask

    task automatic reg_read(input logic [8:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_if.reg_rd   = 1'b1;
        bus_if.reg_addr = a;
        @(negedge clk);
        bus_if.reg_rd   = 1'b0;
        d = bus_if.reg_rdata;
    endtask

    task automatic read_chk(input string tag, input logic [8:0] a, input logic [31:0] exp);
        logic [31:0] d;
        reg_read(a, d);
        chk(tag, d, exp);
    endtask

    initial begin
        bus_if.reg_wr    = 1'b0;
        bus_if.reg_rd    = 1'b0;
        bus_if.reg_addr  = '0;
        bus_if.reg_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rdata", bus_if.reg_rdata, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        rst = 1'b0;
        read_chk("rst_ctrl0", 9'h000, 32'h0);
        read_chk("rst_summary", 9'h100, 32'h0);

        // ch0 mode GE, THR=8, level ramps 7 -> 8
        reg_write(9'h004, 32'd8);
        set_lvl(0, 10'd7);
        reg_write(9'h008, 32'h1);
        reg_write(9'h000, 32'h1);
        read_chk("ch0_stat_lvl7", 9'h008, 32'h0007_0000);
        chk("ch0_irq_lvl7", {31'b0, irq}, 32'h0);
        @(negedge clk);
        set_lvl(0, 10'd8);
        bus_if.reg_rd   = 1'b1;
        bus_if.reg_addr = 9'h008;
        @(negedge clk);
        chk("ch0_stat_edge", bus_if.reg_rdata, 32'h0008_0000);
        chk("ch0_irq_edge", {31'b0, irq}, 32'h0);
        @(negedge clk);
        bus_if.reg_rd = 1'b0;
        chk("ch0_stat_pend", bus_if.reg_rdata, 32'h0008_0001);
        chk("ch0_irq_next", {31'b0, irq}, {31'b0, FAST_IRQ});
        set_lvl(0, 10'd0);
        reg_write(9'h008, 32'h1);
        read_chk("ch0_stat_w1c", 9'h008, 32'h0);
        chk("ch0_irq_clr", {31'b0, irq}, 32'h0);

        // ch1 mode LT, THR=4: set wins over W1C while the condition holds
        set_lvl(1, 10'd2);
        reg_write(9'h014, 32'd4);
        reg_write(9'h010, 32'h3);
        read_chk("ch1_ctrl", 9'h010, 32'h3);
        for (int i = 0; i < 4; i++) reg_write(9'h018, 32'h1);
        read_chk("ch1_set_wins", 9'h018, 32'h0002_0001);
        set_lvl(1, 10'd4);
        @(negedge clk);
        reg_write(9'h018, 32'h1);
        read_chk("ch1_stat_clr", 9'h018, 32'h0004_0000);
        chk("ch1_irq_clr", {31'b0, irq}, 32'h0);
        read_chk("ch1_summary", 9'h100, 32'h0);

        // Unmapped space and disabled channel with a true condition
        reg_write(9'h0C0, 32'hFFFF_FFFF);
        reg_write(9'h104, 32'hFFFF_FFFF);
        read_chk("unmapped_0c0", 9'h0C0, 32'h0);
        read_chk("unmapped_104", 9'h104, 32'h0);
        read_chk("ch2_pend_dis", 9'h028, 32'h0000_0001);
        read_chk("ch2_summary", 9'h100, 32'h0);
        chk("ch2_irq_dis", {31'b0, irq}, 32'h0);

        // THR zero-extension and CTRL field masking on ch3
        reg_write(9'h034, 32'hFFFF_FFFF);
        read_chk("ch3_thr_ext", 9'h034, 32'h0000_03FF);
        reg_write(9'h038, 32'h1);
        reg_write(9'h030, 32'h0000_00FF);
        read_chk("ch3_ctrl_mask", 9'h030, 32'h7);
        read_chk("ch3_stat_never", 9'h038, 32'h0);

        // ch2 error counter saturation at 2^ERR_W-1
        reg_write(9'h02C, 32'h0);
        @(negedge clk);
        err_evt[2] = 1'b1;
        repeat (3) @(negedge clk);
        err_evt[2] = 1'b0;
        read_chk("ch2_err_3", 9'h02C, 32'd3);
        @(negedge clk);
        err_evt[2] = 1'b1;
        repeat (17) @(negedge clk);
        err_evt[2] = 1'b0;
        read_chk("ch2_err_sat", 9'h02C, 32'd15);
        @(negedge clk);
        bus_if.reg_wr    = 1'b1;
        bus_if.reg_addr  = 9'h02C;
        bus_if.reg_wdata = 32'h0;
        err_evt[2]       = 1'b1;
        @(negedge clk);
        bus_if.reg_wr    = 1'b0;
        err_evt[2]       = 1'b0;
        read_chk("ch2_err_wr_evt", 9'h02C, 32'd1);
        reg_write(9'h02C, 32'h0);
        read_chk("ch2_err_wr", 9'h02C, 32'd0);

`ifdef S9IO_IRQ_COALESCE_EN
        // Pending held for 63 observed cycles: irq must stay low
        @(negedge clk);
        set_lvl(0, 10'd8);
        @(negedge clk);
        set_lvl(0, 10'd0);
        repeat (62) @(negedge clk);
        chk("coal63_pre", {31'b0, irq}, 32'h0);
        bus_if.reg_wr    = 1'b1;
        bus_if.reg_addr  = 9'h008;
        bus_if.reg_wdata = 32'h1;
        @(negedge clk);
        bus_if.reg_wr    = 1'b0;
        chk("coal63_edge", {31'b0, irq}, 32'h0);
        repeat (3) @(negedge clk);
        chk("coal63_after", {31'b0, irq}, 32'h0);
        // Pending held for 64 observed cycles: irq rises once
        set_lvl(0, 10'd8);
        @(negedge clk);
        set_lvl(0, 10'd0);
        repeat (63) @(negedge clk);
        chk("coal64_pre", {31'b0, irq}, 32'h0);
        bus_if.reg_wr = 1'b1;
        @(negedge clk);
        bus_if.reg_wr = 1'b0;
        chk("coal64_fire", {31'b0, irq}, 32'h1);
        @(negedge clk);
        chk("coal64_drop", {31'b0, irq}, 32'h0);
`endif

        // Reset in the middle of a pending irq and a read
        reg_write(9'h000, 32'h5);
        set_lvl(0, 10'd5);
        @(negedge clk);
        err_evt[2] = 1'b1;
        repeat (2) @(negedge clk);
        err_evt[2] = 1'b0;
        repeat (70) @(negedge clk);
        chk("pre_rst_irq", {31'b0, irq}, 32'h1);
        read_chk("pre_rst_ctrl", 9'h000, 32'h5);
        @(negedge clk);
        bus_if.reg_rd   = 1'b1;
        bus_if.reg_addr = 9'h02C;
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_irq", {31'b0, irq}, 32'h0);
        chk("mid_rst_rdata", bus_if.reg_rdata, 32'h0);
        set_lvl(0, 10'd0);
        @(negedge clk);
        bus_if.reg_rd = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            read_chk($sformatf("post_rst_ctrl%0d", c), 9'(c * 16),      32'h0);
            read_chk($sformatf("post_rst_thr%0d", c),  9'(c * 16 + 4),  32'h0);
            read_chk($sformatf("post_rst_err%0d", c),  9'(c * 16 + 12), 32'h0);
        end
        read_chk("post_rst_summary", 9'h100, 32'h0);
        chk("post_rst_irq", {31'b0, irq}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/s9io_irq_ctrl.md
S9IO_IRQ_CTRL -- requirements
Module: s9io_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of monitored FIFO channels (1..8).
REQ-002 SHALL have parameter LVL_W, default 10, width of FIFO level inputs and thresholds.
REQ-003 SHALL have parameter ERR_W, default 16, width of per-channel saturating error counters.
REQ-004 SHALL have parameter COAL_CYCLES, default 64, coalescing hold time in clk cycles; used only with S9IO_IRQ_COALESCE_EN.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port fifo_lvl  input  NUM_CH*LVL_W  current word count per channel, channel 0 in LSBs.
REQ-008 SHALL have port err_evt  input  NUM_CH  one-cycle pulse per dropped frame per channel.
REQ-009 SHALL have port reg_wr  input  1  register write strobe.
REQ-010 SHALL have port reg_rd  input  1  register read strobe.
REQ-011 SHALL have port reg_addr  input  9  byte address, word aligned.
REQ-012 SHALL have port reg_wdata  input  32  write data.
REQ-013 SHALL have port reg_rdata  output  32  read data, valid one cycle after reg_rd.
REQ-014 SHALL have port irq  output  1  aggregated interrupt request.

Function
REQ-015 SHALL map channel n registers at n*0x10: +0x0 CTRL, +0x4 THR, +0x8 STAT, +0xC ERR_CNT; global IRQ_SUMMARY at 0x100.
REQ-016 SHALL define CTRL as bit0 irq enable and bits 2:1 mode (0: lvl >= THR, 1: lvl < THR, 2: lvl != 0, 3: never); CTRL and THR are read/write.
REQ-017 SHALL define STAT as bit0 pending (write 1 to clear) and bits LVL_W+15:16 the live fifo_lvl; level bits are read-only.
REQ-018 SHALL set a channel's pending on every cycle its condition is true, independent of enable; pending is sticky until cleared.
REQ-019 SHALL let set win over W1C in the same cycle, so a true condition re-asserts pending on the next cycle.
REQ-020 SHALL increment ERR_CNT by one per err_evt cycle and saturate at 2^ERR_W-1 with no wrap.
REQ-021 SHALL clear ERR_CNT on any write to it; a coincident err_evt SHALL leave it at 1.
REQ-022 SHALL return pending AND enable per channel in IRQ_SUMMARY bits NUM_CH-1:0, read-only.
REQ-023 SHALL return 0 for reads of unmapped addresses or channels >= NUM_CH and SHALL ignore writes there.
REQ-024 SHALL zero-extend THR to LVL_W bits on write; upper wdata bits are ignored and read back as 0.
REQ-025 SHALL, without coalescing, register irq as OR of (pending AND enable), asserting one cycle after pending sets.

Reset
REQ-026 SHALL on rst clear all CTRL, THR, pending, ERR_CNT and the coalescing counter, and drive reg_rdata=0 and irq=0.
REQ-027 SHALL treat rst asserted mid-operation as immediate, discarding in-flight reads; the first read after release returns reset values.

Configuration
REQ-028 SHALL, when S9IO_IRQ_COALESCE_EN is defined, assert irq only after any enabled pending has stayed set continuously for COAL_CYCLES cycles, then hold it until no enabled pending remains.
REQ-029 SHALL reset the coalescing counter whenever no enabled pending exists.
REQ-030 SHALL, when S9IO_IRQ_COALESCE_EN is undefined, omit the counter and follow REQ-025.

Structure
REQ-031 SHALL place register offsets, CTRL bit positions, mode encodings and the summary address in shared package s9io_pkg.
REQ-032 SHALL implement per-channel state (CTRL, THR, pending, ERR_CNT) in sub-module s9io_irq_ch, instantiated NUM_CH times by generate.

Verification
REQ-033 SHALL cover: ch0 CTRL=0x1 (mode 0), THR=8, fifo_lvl0 ramps 7->8 -> STAT.pending=1 on the cycle after lvl=8, irq=1 one cycle later.
REQ-034 SHALL cover: ch1 mode 1, THR=4, lvl=2, W1C STAT every cycle -> pending reads 1 (set wins); raise lvl to 4 then W1C -> pending=0, irq=0.
REQ-035 SHALL cover: ERR_W=4, 20 err_evt pulses on ch2 -> ERR_CNT=15; write ERR_CNT coincident with err_evt -> 1.
REQ-036 SHALL cover: read address 0x0C0 with NUM_CH=4 -> 0; CTRL enable=0 with condition true -> STAT.pending=1, IRQ_SUMMARY=0, irq=0.
REQ-037 SHALL cover: with S9IO_IRQ_COALESCE_EN and COAL_CYCLES=64, pending held 63 cycles then cleared -> irq stays 0; pending held 64 cycles -> irq=1.
REQ-038 SHALL cover: assert rst during a pending irq and a reg_rd -> irq=0 and reg_rdata=0 immediately; all registers read 0 after release.
